// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Brief    : Shared state encoding and default timing for the scan address
//            generator.
// Revision : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int DEF_ADDR_W       = 4;
    localparam int DEF_DWELL_CYCLES = 1000;
    localparam int DEF_BLANK_CYCLES = 8;
    localparam int DEF_CNT_W        = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_BLANK = 2'd1;
    localparam state_t S_DWELL = 2'd2;

endpackage
`default_nettype wire

// File: rtl/scan_next_pos.sv
`default_nettype none
// ============================================================================
// Module   : scan_next_pos
// Brief    : Eligible-position search: next above the current position,
//            lowest, highest, wrap and empty indications.
// Revision : 1.0 - initial release
// ============================================================================
module scan_next_pos
    import scan_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [2**ADDR_W-1:0] i_pos_mask,
    input  logic [ADDR_W-1:0]    i_last_pos,
    input  logic [ADDR_W-1:0]    i_cur,
    output logic [ADDR_W-1:0]    o_next_pos,
    output logic                 o_wrap,
    output logic [ADDR_W-1:0]    o_first_pos,
    output logic [ADDR_W-1:0]    o_high_pos,
    output logic                 o_empty
);

    localparam int c_NPOS = 2**ADDR_W;

    logic [c_NPOS-1:0] w_elig;
    logic              w_has_next;

    generate
        for (genvar gi = 0; gi < c_NPOS; gi++) begin : g_elig
            assign w_elig[gi] = i_pos_mask[gi] & (ADDR_W'(gi) <= i_last_pos);
        end
    endgenerate

    // Descending scan leaves the lowest match; ascending scan the highest.
    always_comb begin
        o_next_pos  = '0;
        o_first_pos = '0;
        o_high_pos  = '0;
        w_has_next  = 1'b0;
        for (int i = c_NPOS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                o_first_pos = ADDR_W'(i);
                if (ADDR_W'(i) > i_cur) begin
                    o_next_pos = ADDR_W'(i);
                    w_has_next = 1'b1;
                end
            end
        end
        for (int i = 0; i < c_NPOS; i++) begin
            if (w_elig[i]) begin
                o_high_pos = ADDR_W'(i);
            end
        end
    end

    assign o_empty = ~|w_elig;
    assign o_wrap  = ~w_has_next;

endmodule
`default_nettype wire

// File: rtl/scan_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_addr_gen
// Brief    : Round-robin select/enable generator for a 4-to-16 decoder with
//            programmable dwell, blanking gap and per-position skip mask.
// Revision : 1.0 - initial release
// ============================================================================
module scan_addr_gen
    import scan_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [2**ADDR_W-1:0] pos_mask,
    input  logic [ADDR_W-1:0]    last_pos,
    output logic [ADDR_W-1:0]    addr,
    output logic                 addr_en,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam state_t c_ENTRY = (BLANK_CYCLES > 0) ? S_BLANK : S_DWELL;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_addr_en;
    logic               r_frame_start;
    logic               r_frame_done;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_fs_nxt;
    logic               w_fd_nxt;

    logic [ADDR_W-1:0]  w_next_pos;
    logic [ADDR_W-1:0]  w_first_pos;
    logic [ADDR_W-1:0]  w_high_pos;
    logic               w_wrap;
    logic               w_empty;

    scan_next_pos #(
        .ADDR_W (ADDR_W)
    ) u_next_pos (
        .i_pos_mask  (pos_mask),
        .i_last_pos  (last_pos),
        .i_cur       (r_addr),
        .o_next_pos  (w_next_pos),
        .o_wrap      (w_wrap),
        .o_first_pos (w_first_pos),
        .o_high_pos  (w_high_pos),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_fs_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run && !w_empty) begin
                    w_state_nxt = c_ENTRY;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = w_first_pos;
                    w_fs_nxt    = 1'b1;
                end
            end
            S_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_nxt = S_DWELL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DWELL: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    if (!run || w_empty) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = c_ENTRY;
                        w_addr_nxt  = w_wrap ? w_first_pos : w_next_pos;
                        w_fs_nxt    = w_wrap;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Look one cycle ahead so frame_done can be a flop yet coincide with the
    // last dwell cycle of the highest eligible position.
    assign w_fd_nxt = (w_state_nxt == S_DWELL) && (w_cnt_nxt == c_DWELL_LAST) &&
                      (w_addr_nxt >= w_high_pos);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_addr_en     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_addr        <= w_addr_nxt;
            r_addr_en     <= (w_state_nxt == S_DWELL);
            r_frame_start <= w_fs_nxt;
            r_frame_done  <= w_fd_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    assign addr        = r_addr;
    assign addr_en     = r_addr_en;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
Sequential address generator that sits directly upstream of decoder_4_to_16. It drives the decoder's 4-bit select input and an enable strobe that gates the decoder's active-high enable. Positions are stepped through round-robin with a programmable dwell time and a blanking gap between positions, so the decoder output never shows two active lines or a glitch. Disabled positions are skipped. Typical use is scanning LED digits or matrix rows.

Parameters:
ADDR_W, 4, width of addr; number of positions is 2**ADDR_W (16)
DWELL_CYCLES, 1000, clk cycles addr_en stays high per position; must be >= 1
BLANK_CYCLES, 8, clk cycles addr_en stays low before each position; 0 means no blanking
CNT_W, 16, width of the internal dwell/blank counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
run  input  1  level; 1 = scan, 0 = stop after the current position
pos_mask  input  2**ADDR_W  bit i = 1 enables position i
last_pos  input  ADDR_W  highest position in the scan; positions > last_pos are skipped
addr  output  ADDR_W  select code to the decoder A input; registered
addr_en  output  1  decoder enable; registered; high only during DWELL
frame_start  output  1  one-cycle pulse on the first BLANK cycle of a frame's first position
frame_done  output  1  one-cycle pulse on the last DWELL cycle of a frame's last position
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset: on rst=1 at a clk edge, the next state is IDLE. Outputs are addr=0, addr_en=0, frame_start=0, frame_done=0, busy=0, and the counter is 0. Reset mid-scan aborts immediately with no finishing dwell.
- Eligible set: positions i with pos_mask[i]=1 and i <= last_pos. The mask and last_pos are sampled only at selection time.
- States:
  - IDLE: if run=1 and the eligible set is non-empty, load addr with the lowest eligible position and go to BLANK (or DWELL if BLANK_CYCLES=0). Assert frame_start that cycle. If the set is empty, stay in IDLE.
  - BLANK: addr_en=0 for BLANK_CYCLES cycles, then go to DWELL.
  - DWELL: addr_en=1 for DWELL_CYCLES cycles. On the last cycle, select the next position.
- Next-position selection: the next eligible position above addr.
  - If none exists, wrap to the lowest eligible position. That wrap ends the frame: assert frame_done on the last DWELL cycle, and assert frame_start on the following BLANK cycle.
  - If the eligible set became empty, go to IDLE.
  - If run=0 at the last DWELL cycle, go to IDLE (graceful stop) and keep addr unchanged. frame_done asserts only if this was the frame's last position.
- addr changes only on entry to BLANK (or entry to DWELL when BLANK_CYCLES=0, in which case addr_en drops for zero cycles). addr is therefore stable for the whole time addr_en=1.
- Single eligible position: it repeats, and frame_start and frame_done both pulse every period.
- Latency: run rising in IDLE gives addr valid on the next cycle, and addr_en rises BLANK_CYCLES cycles after that.
- Frame period: (#eligible) × (BLANK_CYCLES + DWELL_CYCLES) cycles.
- run toggling during BLANK or mid-DWELL has no effect until the last DWELL cycle.

Decomposition:
- Package scan_pkg: state enum (IDLE, BLANK, DWELL), default DWELL/BLANK constants, ADDR_W default.
- Sub-module scan_next_pos: combinational logic taking pos_mask, last_pos and the current addr. It returns the next eligible position, a wrap flag, a first-eligible position and an empty flag.

Test Plan:
1. DWELL=4, BLANK=2, mask=0xFFFF, last_pos=3, run=1 → addr sequence 0,1,2,3,0. Each position gives 2 cycles addr_en=0 then 4 cycles addr_en=1. Frame period is 24 cycles. frame_done pulses on the 4th DWELL cycle of position 3, and frame_start pulses on the next cycle.
2. mask=0x0005, last_pos=15 → addr alternates 0,2,0,2. Positions 1 and 3–15 never appear.
3. mask=0x0000, run=1 → stays IDLE. busy=0, addr_en=0, and no pulses for 100 cycles.
4. run drops on the 2nd DWELL cycle of position 1 → addr_en stays high for 2 more cycles, then IDLE. addr=1, busy=0, and no frame_done.
5. rst=1 mid-DWELL of position 2 → next cycle addr=0, addr_en=0, busy=0. With run still 1 after rst releases, restarts at position 0 with frame_start.
6. mask=0x8000, last_pos=15 → addr fixed at 15. frame_start and frame_done each pulse once every 6 cycles. With last_pos=14 instead, the block stays IDLE.
